// File: rtl/nanci_mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nanci_mesh_pkg
// Description : Shared mesh definitions: direction codes, flit field
//               offsets and the dimension-ordered (XY) first-hop function.
// Revision    : 1.0 - initial release
// ============================================================================
package nanci_mesh_pkg;

    // Direction code width and values.
    localparam int DIR_W = 3;
    localparam logic [DIR_W-1:0] DIR_LOCAL = 3'd0;
    localparam logic [DIR_W-1:0] DIR_EAST  = 3'd1;
    localparam logic [DIR_W-1:0] DIR_WEST  = 3'd2;
    localparam logic [DIR_W-1:0] DIR_NORTH = 3'd3;
    localparam logic [DIR_W-1:0] DIR_SOUTH = 3'd4;

    // Widest coordinate route_xy accepts; callers zero-extend into this.
    localparam int COORD_MAX_W = 8;

    // Flit layout, MSB first: {dst_x, dst_y, src_x, src_y, data}.
    localparam int FLIT_DATA_LSB = 0;

    function automatic int flit_src_y_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int flit_src_x_lsb(input int data_w, input int coord_w);
        return data_w + coord_w;
    endfunction

    function automatic int flit_dst_y_lsb(input int data_w, input int coord_w);
        return data_w + 2 * coord_w;
    endfunction

    function automatic int flit_dst_x_lsb(input int data_w, input int coord_w);
        return data_w + 3 * coord_w;
    endfunction

    function automatic int flit_width(input int data_w, input int coord_w);
        return data_w + 4 * coord_w;
    endfunction

    // XY routing: resolve the column first, then the row; unsigned compare.
    function automatic logic [DIR_W-1:0] route_xy(
        input logic [COORD_MAX_W-1:0] dst_x,
        input logic [COORD_MAX_W-1:0] dst_y,
        input logic [COORD_MAX_W-1:0] self_x,
        input logic [COORD_MAX_W-1:0] self_y
    );
        if (dst_x > self_x)      return DIR_EAST;
        else if (dst_x < self_x) return DIR_WEST;
        else if (dst_y > self_y) return DIR_NORTH;
        else if (dst_y < self_y) return DIR_SOUTH;
        else                     return DIR_LOCAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mesh_sync_fifo
// Description : Single-clock FIFO with occupancy count and full/empty flags.
//               A push while full or a pop while empty is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_DEPTH = c_CNT_W'(DEPTH);

    // Controller states, a function of occupancy.
    localparam logic [1:0] c_ST_EMPTY  = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_FULL   = 2'd2;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [1:0]         r_state;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && (r_state != c_ST_FULL);
    assign w_do_pop  = i_pop  && (r_state != c_ST_EMPTY);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_CNT_ONE;
            2'b01:   w_count_nxt = r_count - c_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, occupancy and state update; state tracks the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= c_ST_EMPTY;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count <= w_count_nxt;
            if (w_count_nxt == c_CNT_ZERO)       r_state <= c_ST_EMPTY;
            else if (w_count_nxt == c_CNT_DEPTH) r_state <= c_ST_FULL;
            else                                 r_state <= c_ST_ACTIVE;
        end
    end

    // Storage write; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = (r_state == c_ST_FULL);
    assign o_empty   = (r_state == c_ST_EMPTY);

endmodule
`default_nettype wire

// File: rtl/mesh_injector.sv
`default_nettype none
// ============================================================================
// Module      : mesh_injector
// Description : Per-node injection stage ahead of the mesh. Buffers local
//               packets, stamps source coordinates, precomputes the XY
//               first-hop direction and counts flits taken by the mesh.
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_injector
    import nanci_mesh_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 2,
    parameter int DEPTH   = 4,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [COORD_W-1:0]        in_dst_x,
    input  logic [COORD_W-1:0]        in_dst_y,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W+4*COORD_W-1:0] out_flit,
    output logic [2:0]                out_dir,
    output logic [15:0]               inj_count
);

    localparam int c_FLIT_W  = flit_width(DATA_W, COORD_W);
    localparam int c_ENTRY_W = c_FLIT_W + DIR_W;
    localparam int c_CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [COORD_W-1:0] c_SELF_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] c_SELF_Y = COORD_W'(Y_ID);

    logic [DIR_W-1:0]     w_dir;
    logic [c_FLIT_W-1:0]  w_flit;
    logic [c_ENTRY_W-1:0] w_rd_entry;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 r_run;
    logic [15:0]          r_inj_count;

    // First hop is resolved once, at enqueue, from the incoming destination.
    assign w_dir  = route_xy(COORD_MAX_W'(in_dst_x), COORD_MAX_W'(in_dst_y),
                             COORD_MAX_W'(c_SELF_X), COORD_MAX_W'(c_SELF_Y));
    assign w_flit = {in_dst_x, in_dst_y, c_SELF_X, c_SELF_Y, in_data};

    // Holds in_ready low through reset and until the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    // No combinational path from out_ready: a full queue refuses the push.
    assign in_ready  = r_run && !w_full;
    assign out_valid = (w_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    mesh_sync_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_wr_data ({w_flit, w_dir}),
        .i_pop     (w_pop),
        .o_rd_data (w_rd_entry),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    // Head entry is masked to zero when nothing is queued.
    assign {out_flit, out_dir} = w_empty ? '0 : w_rd_entry;

    // Flits accepted by the mesh; wraps modulo 2^16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_inj_count <= '0;
        else if (w_pop) r_inj_count <= r_inj_count + 16'd1;
    end

    assign inj_count = r_inj_count;

endmodule
`default_nettype wire

// File: tb/tb_mesh_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_injector
// Description : Self-checking bench for mesh_injector at node (1,1) against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_injector;

    typedef struct packed {
        logic [39:0] flit;
        logic [2:0]  dir;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_dst_x = '0;
    logic [1:0]  in_dst_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [39:0] out_flit;
    logic [2:0]  out_dir;
    logic [15:0] inj_count;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t        mq[$];
    logic [15:0] m_inj = '0;
    bit          m_run = 1'b0;

    always #5 clk = ~clk;

    mesh_injector #(
        .DATA_W  (32),
        .COORD_W (2),
        .DEPTH   (4),
        .X_ID    (1),
        .Y_ID    (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dst_x  (in_dst_x),
        .in_dst_y  (in_dst_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_flit  (out_flit),
        .out_dir   (out_dir),
        .inj_count (inj_count)
    );

    // XY rule for a node sitting at (1,1).
    function automatic logic [2:0] ref_dir(input int dx, input int dy);
        if (dx > 1)      return 3'd1;
        else if (dx < 1) return 3'd2;
        else if (dy > 1) return 3'd3;
        else if (dy < 1) return 3'd4;
        else             return 3'd0;
    endfunction

    function automatic ent_t mk_entry(input logic [1:0] dx, input logic [1:0] dy,
                                      input logic [31:0] d);
        ent_t e;
        e.flit = {dx, dy, 2'd1, 2'd1, d};
        e.dir  = ref_dir(int'(dx), int'(dy));
        return e;
    endfunction

    function automatic ent_t head();
        ent_t e;
        e = '0;
        if (mq.size() != 0) e = mq[0];
        return e;
    endfunction

    // Drive one cycle, advance the model at the edge, return 1 time unit later.
    task automatic cycle(input bit v, input logic [1:0] dx, input logic [1:0] dy,
                         input logic [31:0] d, input bit ordy);
        bit   do_push;
        bit   do_pop;
        ent_t tmp;
        in_valid  = v;
        in_dst_x  = dx;
        in_dst_y  = dy;
        in_data   = d;
        out_ready = ordy;
        do_push = v && m_run && (mq.size() < 4);
        do_pop  = ordy && (mq.size() != 0);
        @(posedge clk);
        if (do_pop) begin
            tmp = mq.pop_front();
            m_inj = m_inj + 16'd1;
        end
        if (do_push) mq.push_back(mk_entry(dx, dy, d));
        m_run = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_flit !== 40'd0) begin n_fail++; $display("FAIL rst_out_flit: got %h want 0", out_flit); end
        n_checks++; if (out_dir !== 3'd0) begin n_fail++; $display("FAIL rst_out_dir: got %0d want 0", out_dir); end
        n_checks++; if (inj_count !== 16'd0) begin n_fail++; $display("FAIL rst_inj_count: got %0d want 0", inj_count); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready_early: got %b want 0", in_ready); end
        cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b0);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        cycle(1'b1, 2'd3, 2'd1, 32'hA5A5A5A5, 1'b1);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_checks++; if (out_dir !== 3'd1) begin n_fail++; $display("FAIL single_dir: got %0d want 1", out_dir); end
        n_checks++; if (out_flit !== {2'd3, 2'd1, 2'd1, 2'd1, 32'hA5A5A5A5}) begin n_fail++; $display("FAIL single_flit: got %h want %h", out_flit, {2'd3, 2'd1, 2'd1, 2'd1, 32'hA5A5A5A5}); end
        cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
        n_checks++; if (inj_count !== 16'd1) begin n_fail++; $display("FAIL single_inj_count: got %0d want 1", inj_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back_dirs();
        logic [1:0] dxs [4];
        logic [1:0] dys [4];
        logic [2:0] exp_dir [4];
        dxs = '{2'd0, 2'd1, 2'd1, 2'd1};
        dys = '{2'd1, 2'd3, 2'd0, 2'd1};
        exp_dir = '{3'd2, 3'd3, 3'd4, 3'd0};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, dxs[i], dys[i], 32'h100 + 32'(i), 1'b1);
            n_checks++; if (out_dir !== exp_dir[i]) begin n_fail++; $display("FAIL b2b_dir[%0d]: got %0d want %0d", i, out_dir, exp_dir[i]); end
            n_checks++; if (out_flit[31:0] !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_flit[31:0], 32'h100 + 32'(i)); end
        end
        cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
        n_checks++; if (inj_count !== m_inj) begin n_fail++; $display("FAIL b2b_inj_count: got %0d want %0d", inj_count, m_inj); end
    endtask

    task automatic test_backpressure_full();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2'(i), 2'd2, 32'h1000 + 32'(i), 1'b0);
            n_checks++; if (in_ready !== (i < 3)) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, in_ready, (i < 3)); end
            n_checks++; if (out_flit[31:0] !== 32'h1000) begin n_fail++; $display("FAIL bp_stall_stable[%0d]: got %h want 00001000", i, out_flit[31:0]); end
        end
        // full, 5th still offered, pop only
        cycle(1'b1, 2'd0, 2'd2, 32'h1004, 1'b1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_ready: got %b want 1", in_ready); end
        n_checks++; if (out_flit[31:0] !== 32'h1001) begin n_fail++; $display("FAIL full_pop_head: got %h want 00001001", out_flit[31:0]); end
        // push and pop together, occupancy stays at 3
        cycle(1'b1, 2'd0, 2'd2, 32'h1004, 1'b1);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_ready: got %b want 1", in_ready); end
        for (int k = 2; k < 5; k++) begin
            n_checks++; if (out_flit !== head().flit || out_flit[31:0] !== 32'h1000 + 32'(k)) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want data %h", k, out_flit, 32'h1000 + 32'(k)); end
            cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %b want 0", out_valid); end
        n_checks++; if (inj_count !== m_inj) begin n_fail++; $display("FAIL bp_inj_count: got %0d want %0d", inj_count, m_inj); end
    endtask

    task automatic test_random();
        ent_t e;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  $urandom, ($urandom % 3) != 0);
            e = head();
            n_checks++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, out_valid, (mq.size() != 0)); end
            n_checks++; if (in_ready !== (mq.size() < 4)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, in_ready, (mq.size() < 4)); end
            n_checks++; if (out_flit !== e.flit) begin n_fail++; $display("FAIL rnd_flit[%0d]: got %h want %h", i, out_flit, e.flit); end
            n_checks++; if (out_dir !== e.dir) begin n_fail++; $display("FAIL rnd_dir[%0d]: got %0d want %0d", i, out_dir, e.dir); end
            n_checks++; if (inj_count !== m_inj) begin n_fail++; $display("FAIL rnd_inj_count[%0d]: got %0d want %0d", i, inj_count, m_inj); end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd2, 2'd3, 32'hBEEF0000 + 32'(i), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", out_valid); end
        n_checks++; if (inj_count !== 16'd0) begin n_fail++; $display("FAIL arst_inj_count: got %0d want 0", inj_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b want 0", in_ready); end
        n_checks++; if (out_flit !== 40'd0) begin n_fail++; $display("FAIL arst_flit: got %h want 0", out_flit); end
        mq.delete();
        m_inj = '0;
        m_run = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
            n_checks++; if (out_valid !== 1'b0 || inj_count !== 16'd0) begin n_fail++; $display("FAIL arst_stale[%0d]: got valid %b count %0d want 0 0", i, out_valid, inj_count); end
        end
    endtask

    task automatic test_wrap();
        int gaps = 0;
        for (int i = 0; i < 65537; i++) begin
            cycle(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, 1'b1);
            if (out_valid !== 1'b1) gaps++;
            if (m_inj == 16'hFFFF) begin
                n_checks++; if (inj_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want ffff", inj_count); end
            end
        end
        n_checks++; if (gaps !== 0) begin n_fail++; $display("FAIL wrap_throughput: got %0d empty cycles want 0", gaps); end
        n_checks++; if (inj_count !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", inj_count); end
        cycle(1'b0, 2'd0, 2'd0, 32'd0, 1'b1);
        n_checks++; if (inj_count !== 16'd1) begin n_fail++; $display("FAIL wrap_one: got %0d want 1", inj_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back_dirs();
        test_backpressure_full();
        test_random();
        test_async_reset();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
